// File: rtl/regfile_port_arbiter.sv
// Two-requester round-robin arbiter for a single register-file access port.
// Each granted operation runs IDLE -> ACCESS -> DONE with all outputs registered.
module regfile_port_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              a_done,
   output logic              b_done,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] rf_sel,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t r_state;
   logic   r_ptr_b;
   logic   r_gnt_b;
   logic   r_we;
   logic   w_gnt_b;

   // B wins only when A is absent or B holds the priority pointer.
   assign w_gnt_b = b_req && (!a_req || r_ptr_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ptr_b    <= 1'b0;
         r_gnt_b    <= 1'b0;
         r_we       <= 1'b0;
         a_done     <= 1'b0;
         b_done     <= 1'b0;
         busy       <= 1'b0;
         rdata      <= '0;
         rf_sel     <= '0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         a_done   <= 1'b0;
         b_done   <= 1'b0;
         rf_wr_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (a_req || b_req) begin
                  r_gnt_b    <= w_gnt_b;
                  r_we       <= w_gnt_b ? b_we : a_we;
                  rf_sel     <= w_gnt_b ? b_addr : a_addr;
                  rf_wr_addr <= w_gnt_b ? b_addr : a_addr;
                  rf_wr_data <= w_gnt_b ? b_wdata : a_wdata;
                  rf_wr_en   <= w_gnt_b ? b_we : a_we;
                  busy       <= 1'b1;
                  r_state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (!r_we) begin
                  rdata <= rf_rd_data;
               end
               a_done  <= !r_gnt_b;
               b_done  <= r_gnt_b;
               r_state <= DONE;
            end
            DONE: begin
               r_ptr_b <= !r_gnt_b;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with a behavioural register file.
module tb_regfile_port_arbiter;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NREG   = 32;

   typedef struct packed {
      logic              is_rd;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
   logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
   logic              a_done, b_done, busy, rf_wr_en;
   logic [DATA_W-1:0] rdata, rf_rd_data, rf_wr_data;
   logic [ADDR_W-1:0] rf_sel, rf_wr_addr;

   logic              rf_init = 1'b1;
   logic [DATA_W-1:0] rf_mem [NREG];
   logic [DATA_W-1:0] model  [NREG];

   exp_t              q_a[$];
   exp_t              q_b[$];
   int                done_log[$];
   int                done_cyc[$];
   logic [DATA_W-1:0] exp_hold = '0;
   logic [ADDR_W-1:0] last_wr_addr = '0;
   int                wr_cnt = 0;
   int                cyc = 0;
   int                n_chk = 0;
   int                n_pass = 0;

   regfile_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_req      (a_req),
      .a_we       (a_we),
      .a_addr     (a_addr),
      .a_wdata    (a_wdata),
      .b_req      (b_req),
      .b_we       (b_we),
      .b_addr     (b_addr),
      .b_wdata    (b_wdata),
      .a_done     (a_done),
      .b_done     (b_done),
      .rdata      (rdata),
      .busy       (busy),
      .rf_sel     (rf_sel),
      .rf_rd_data (rf_rd_data),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] init_val(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
   endfunction

   // Register file: combinational read mux, write on rising edge.
   assign rf_rd_data = rf_mem[rf_sel];
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < int'(NREG); i++) rf_mem[i] <= init_val(i);
      end else if (rf_wr_en) begin
         rf_mem[rf_wr_addr] <= rf_wr_data;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Output monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) exp_hold = '0;
      if (rf_wr_en) begin
         wr_cnt++;
         last_wr_addr = rf_wr_addr;
         check("wr_only_when_busy", 64'(busy), 64'd1);
      end
      if (a_done || b_done) begin
         check("done_onehot", 64'(a_done & b_done), 64'd0);
         done_log.push_back(b_done ? 1 : 0);
         done_cyc.push_back(cyc);
         check(b_done ? "b_pending" : "a_pending",
               64'(b_done ? (q_b.size() != 0) : (q_a.size() != 0)), 64'd1);
         if (b_done ? (q_b.size() != 0) : (q_a.size() != 0)) begin
            e = b_done ? q_b.pop_front() : q_a.pop_front();
            if (e.is_rd) exp_hold = e.data;
            check(b_done ? "b_rdata" : "a_rdata", 64'(rdata), 64'(exp_hold));
         end
      end
   end

   task automatic issue(input bit who, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd);
      exp_t e;
      e.is_rd = !we;
      e.data  = model[addr];
      if (we) model[addr] = wd;
      if (who) begin
         q_b.push_back(e);
         b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
      end else begin
         q_a.push_back(e);
         a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
      end
   endtask

   // Waits (bounded) for the requester's done and checks its latency in cycles.
   task automatic wait_done(input bit who, input int lat, input bit keep, input bit chg);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (chg && n == 2) begin
            a_addr  = a_addr + 5'd1;
            a_wdata = ~a_wdata;
         end
         seen = who ? b_done : a_done;
      end
      check(who ? "b_latency" : "a_latency", 64'(n), 64'(lat));
      @(posedge clk); #1;
      if (!keep) begin
         if (who) b_req = 1'b0; else a_req = 1'b0;
      end
   endtask

   task automatic run_op(input bit who, input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int lat, input bit keep,
                         input bit chg);
      issue(who, we, addr, wd);
      wait_done(who, lat, keep, chg);
   endtask

   initial begin
      int w0;
      for (int i = 0; i < int'(NREG); i++) model[i] = init_val(i);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", 64'({a_done, b_done, rf_wr_en, busy}), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_wr_data", 64'(rf_wr_data), 64'd0);
      check("rst_addrs", 64'({rf_sel, rf_wr_addr}), 64'd0);
      rst = 1'b0;
      rf_init = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_quiet", 64'({a_done, b_done, rf_wr_en, busy}), 64'd0);
      end
      @(posedge clk); #1;

      // Both held from reset: pointer starts at A, grants alternate.
      done_log.delete(); done_cyc.delete();
      fork
         begin
            run_op(1'b0, 1'b0, 5'd3, '0, 3, 1'b1, 1'b0);
            run_op(1'b0, 1'b0, 5'd3, '0, 6, 1'b0, 1'b0);
         end
         begin
            run_op(1'b1, 1'b0, 5'd7, '0, 6, 1'b1, 1'b0);
            run_op(1'b1, 1'b0, 5'd7, '0, 6, 1'b0, 1'b0);
         end
      join
      check("alt_count", 64'(done_log.size()), 64'd4);
      for (int i = 0; i < done_log.size(); i++) begin
         check("alt_order", 64'(done_log[i]), 64'(i % 2));
         if (i > 0) check("alt_spacing", 64'(done_cyc[i] - done_cyc[i-1]), 64'd3);
      end

      // A writes 5 then reads it back.
      w0 = wr_cnt;
      run_op(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
      check("wr5_count", 64'(wr_cnt - w0), 64'd1);
      check("wr5_addr", 64'(last_wr_addr), 64'd5);
      check("wr5_mem", 64'(rf_mem[5]), 64'h0000_0000_DEAD_BEEF);
      w0 = wr_cnt;
      run_op(1'b0, 1'b0, 5'd5, '0, 3, 1'b0, 1'b0);
      check("rd5_no_write", 64'(wr_cnt - w0), 64'd0);

      // B alone, back-to-back reads at the address extremes.
      done_log.delete(); done_cyc.delete();
      run_op(1'b1, 1'b0, 5'd0,  '0, 3, 1'b1, 1'b0);
      run_op(1'b1, 1'b0, 5'd31, '0, 3, 1'b1, 1'b0);
      run_op(1'b1, 1'b0, 5'd0,  '0, 3, 1'b1, 1'b0);
      run_op(1'b1, 1'b0, 5'd31, '0, 3, 1'b0, 1'b0);
      check("b_burst_count", 64'(done_log.size()), 64'd4);
      for (int i = 1; i < done_cyc.size(); i++)
         check("b_burst_spacing", 64'(done_cyc[i] - done_cyc[i-1]), 64'd3);

      // A's address and data change during ACCESS must not leak into the write.
      run_op(1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 3, 1'b0, 1'b1);
      check("chg_wr_addr", 64'(last_wr_addr), 64'd9);
      check("chg_mem9", 64'(rf_mem[9]), 64'(model[9]));
      check("chg_mem10", 64'(rf_mem[10]), 64'(model[10]));

      // Reset during a B write's ACCESS; both requests held across reset.
      w0 = wr_cnt;
      issue(1'b1, 1'b1, 5'd12, 32'h1234_5678);
      @(negedge clk);
      @(negedge clk);
      check("rst_acc_wr_en", 64'(rf_wr_en), 64'd1);
      rst = 1'b1;
      issue(1'b0, 1'b0, 5'd20, '0);
      @(posedge clk); #1;
      check("abort_ctrl", 64'({a_done, b_done, rf_wr_en, busy}), 64'd0);
      check("abort_rdata", 64'(rdata), 64'd0);
      check("abort_wr_data", 64'(rf_wr_data), 64'd0);
      check("abort_addrs", 64'({rf_sel, rf_wr_addr}), 64'd0);
      rst = 1'b0;
      done_log.delete(); done_cyc.delete();
      fork
         wait_done(1'b0, 3, 1'b0, 1'b0);
         wait_done(1'b1, 6, 1'b0, 1'b0);
      join
      check("post_rst_count", 64'(done_log.size()), 64'd2);
      if (done_log.size() == 2) check("post_rst_first_a", 64'(done_log[0]), 64'd0);
      check("post_rst_writes", 64'(wr_cnt - w0), 64'd2);
      check("mem12", 64'(rf_mem[12]), 64'h0000_0000_1234_5678);

      repeat (4) @(negedge clk);
      check("q_a_empty", 64'(q_a.size()), 64'd0);
      check("q_b_empty", 64'(q_b.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
